// File: rtl/bram_stream_reader_if.sv
// Request, BRAM read-port and output-stream bundle for bram_stream_reader.
// master = request source / BRAM / consumer side, slave = the reader.
interface bram_stream_reader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic [ADDR_WIDTH-1:0] bram_rd_addr;
  logic                  bram_wr_busy;
  logic [DATA_WIDTH-1:0] bram_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  done;

  modport master (
    output req_valid,
    output req_addr,
    output req_len,
    output bram_wr_busy,
    output bram_rd_data,
    output out_ready,
    input  req_ready,
    input  bram_rd_addr,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_len,
    input  bram_wr_busy,
    input  bram_rd_data,
    input  out_ready,
    output req_ready,
    output bram_rd_addr,
    output out_valid,
    output out_data,
    output out_last,
    output done
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Streams a contiguous (wrapping) BRAM address range out as valid/ready
// beats, tolerating no-change write collisions and consumer backpressure.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input logic clk,
  input logic rst_n,
  bram_stream_reader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  infl_q;
  logic                  infl_last_q;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count_q;
  logic                  done_q;

  logic       accept;
  logic       len_zero;
  logic       pop;
  logic       push;
  logic       issue;
  logic       rem_one;
  logic       head_last;
  logic [2:0] occ;

  assign accept    = bus.req_valid && (state_q == IDLE);
  assign len_zero  = (bus.req_len == '0);
  assign pop       = (count_q != 2'd0) && bus.out_ready;
  assign push      = infl_q;
  assign rem_one   = (rem_q == LEN_WIDTH'(1));
  assign head_last = fifo_last[rd_ptr];

  // Credit: buffered plus in-flight words, less this cycle's pop, stay < 2.
  assign occ   = {1'b0, count_q} + {2'b0, infl_q};
  assign issue = (state_q == STREAM)
              && (rem_q != '0)
              && !bus.bram_wr_busy
              && (occ < (3'd2 + {2'b0, pop}));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !len_zero) state_d = STREAM;
      STREAM:  if (issue && rem_one) state_d = DRAIN;
      DRAIN:   if (pop && head_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      rem_q        <= '0;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      if (accept && !len_zero) begin
        addr_q <= bus.req_addr;
        rem_q  <= bus.req_len;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
      infl_q      <= issue;
      infl_last_q <= issue && rem_one;
      // BRAM output register holds during writes, so capture is always safe.
      if (push) begin
        fifo_data[wr_ptr] <= bus.bram_rd_data;
        fifo_last[wr_ptr] <= infl_last_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      done_q  <= (accept && len_zero)
              || ((state_q == DRAIN) && pop && head_last);
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.bram_rd_addr = addr_q;
  assign bus.out_valid    = (count_q != 2'd0);
  assign bus.out_data     = fifo_data[rd_ptr];
  assign bus.out_last     = (count_q != 2'd0) && head_last;
  assign bus.done         = done_q;

endmodule
